// File: rtl/tcp_tx_ctrl_if.sv
// tcp_tx_ctrl_if: scheduler, TX state/pointer memories, packet-out and update handshakes of the TX controller
interface tcp_tx_ctrl_if #(
  parameter int FLOWID_W = 8,
  parameter int PTR_W = 16,
  parameter int WIN_W = 16
);
  logic sched_tx_req_val;
  logic tx_sched_req_rdy;
  logic [FLOWID_W-1:0] sched_tx_req_flowid;
  logic [FLOWID_W-1:0] tx_pipe_flowid;
  logic curr_tx_state_rd_req_val;
  logic curr_tx_state_rd_req_rdy;
  logic curr_tx_state_rd_resp_val;
  logic curr_tx_state_rd_resp_rdy;
  logic [PTR_W-1:0] curr_tx_state_rd_resp_snd_nxt;
  logic [WIN_W-1:0] curr_tx_state_rd_resp_wnd;
  logic tx_head_ptr_rd_req_val;
  logic tx_head_ptr_rd_req_rdy;
  logic tx_head_ptr_rd_resp_val;
  logic tx_head_ptr_rd_resp_rdy;
  logic [PTR_W-1:0] tx_head_ptr_rd_resp_data;
  logic tx_tail_ptr_rd_req_val;
  logic tx_tail_ptr_rd_req_rdy;
  logic tx_tail_ptr_rd_resp_val;
  logic tx_tail_ptr_rd_resp_rdy;
  logic [PTR_W-1:0] tx_tail_ptr_rd_resp_data;
  logic next_tx_state_wr_req_val;
  logic next_tx_state_wr_req_rdy;
  logic [PTR_W-1:0] next_tx_state_wr_snd_nxt;
  logic tx_hdr_val;
  logic tx_hdr_rdy;
  logic [PTR_W-1:0] tx_hdr_seq;
  logic [PTR_W-1:0] tx_hdr_len;
  logic tx_sched_update_val;
  logic tx_sched_update_rdy;
  logic tx_sched_update_more;
  modport master (
    input  sched_tx_req_val, sched_tx_req_flowid,
    output tx_sched_req_rdy, tx_pipe_flowid,
    output curr_tx_state_rd_req_val, curr_tx_state_rd_resp_rdy,
    input  curr_tx_state_rd_req_rdy, curr_tx_state_rd_resp_val,
    input  curr_tx_state_rd_resp_snd_nxt, curr_tx_state_rd_resp_wnd,
    output tx_head_ptr_rd_req_val, tx_head_ptr_rd_resp_rdy,
    input  tx_head_ptr_rd_req_rdy, tx_head_ptr_rd_resp_val, tx_head_ptr_rd_resp_data,
    output tx_tail_ptr_rd_req_val, tx_tail_ptr_rd_resp_rdy,
    input  tx_tail_ptr_rd_req_rdy, tx_tail_ptr_rd_resp_val, tx_tail_ptr_rd_resp_data,
    output next_tx_state_wr_req_val, next_tx_state_wr_snd_nxt,
    input  next_tx_state_wr_req_rdy,
    output tx_hdr_val, tx_hdr_seq, tx_hdr_len,
    input  tx_hdr_rdy,
    output tx_sched_update_val, tx_sched_update_more,
    input  tx_sched_update_rdy
  );
  modport slave (
    output sched_tx_req_val, sched_tx_req_flowid,
    input  tx_sched_req_rdy, tx_pipe_flowid,
    input  curr_tx_state_rd_req_val, curr_tx_state_rd_resp_rdy,
    output curr_tx_state_rd_req_rdy, curr_tx_state_rd_resp_val,
    output curr_tx_state_rd_resp_snd_nxt, curr_tx_state_rd_resp_wnd,
    input  tx_head_ptr_rd_req_val, tx_head_ptr_rd_resp_rdy,
    output tx_head_ptr_rd_req_rdy, tx_head_ptr_rd_resp_val, tx_head_ptr_rd_resp_data,
    input  tx_tail_ptr_rd_req_val, tx_tail_ptr_rd_resp_rdy,
    output tx_tail_ptr_rd_req_rdy, tx_tail_ptr_rd_resp_val, tx_tail_ptr_rd_resp_data,
    input  next_tx_state_wr_req_val, next_tx_state_wr_snd_nxt,
    output next_tx_state_wr_req_rdy,
    input  tx_hdr_val, tx_hdr_seq, tx_hdr_len,
    output tx_hdr_rdy,
    input  tx_sched_update_val, tx_sched_update_more,
    output tx_sched_update_rdy
  );
endinterface

// File: rtl/tcp_tx_ctrl.sv
// tcp_tx_ctrl: per-flow TX engine; reads state and pointers, sizes the next segment, writes back and reports
module tcp_tx_ctrl #(
  parameter int FLOWID_W = 8,
  parameter int PTR_W = 16,
  parameter int WIN_W = 16,
  parameter int MSS = 1460
) (
  input logic clk,
  input logic rst_n,
  tcp_tx_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ_STATE, WAIT_STATE_RESP, CALCULATE, WRITEBACK, PKT_OUT, SCHEDULE} state_t;
  state_t state, state_nxt;
  logic st_done, hd_done, tl_done, st_cap, hd_cap, tl_cap, more_q;
  logic st_fire, hd_fire, tl_fire, st_got, hd_got, tl_got, reads_done, resps_done;
  logic [FLOWID_W-1:0] flowid;
  logic [PTR_W-1:0] snd_q, head_q, tail_q, len_q;
  logic [WIN_W-1:0] wnd_q;
  logic [PTR_W-1:0] wnd_p, mss_p, avail, inflight, usable, min_au, len_c;
  assign bus.tx_sched_req_rdy = state == IDLE;
  assign bus.tx_pipe_flowid = flowid;
  assign bus.curr_tx_state_rd_req_val = state == READ_STATE && !st_done;
  assign bus.tx_head_ptr_rd_req_val = state == READ_STATE && !hd_done;
  assign bus.tx_tail_ptr_rd_req_val = state == READ_STATE && !tl_done;
  assign bus.curr_tx_state_rd_resp_rdy = state == WAIT_STATE_RESP && !st_cap;
  assign bus.tx_head_ptr_rd_resp_rdy = state == WAIT_STATE_RESP && !hd_cap;
  assign bus.tx_tail_ptr_rd_resp_rdy = state == WAIT_STATE_RESP && !tl_cap;
  assign bus.next_tx_state_wr_req_val = state == WRITEBACK;
  assign bus.next_tx_state_wr_snd_nxt = snd_q + len_q;
  assign bus.tx_hdr_val = state == PKT_OUT;
  assign bus.tx_hdr_seq = snd_q;
  assign bus.tx_hdr_len = len_q;
  assign bus.tx_sched_update_val = state == SCHEDULE;
  assign bus.tx_sched_update_more = more_q;
  assign st_fire = bus.curr_tx_state_rd_req_val & bus.curr_tx_state_rd_req_rdy;
  assign hd_fire = bus.tx_head_ptr_rd_req_val & bus.tx_head_ptr_rd_req_rdy;
  assign tl_fire = bus.tx_tail_ptr_rd_req_val & bus.tx_tail_ptr_rd_req_rdy;
  assign st_got = bus.curr_tx_state_rd_resp_val & bus.curr_tx_state_rd_resp_rdy;
  assign hd_got = bus.tx_head_ptr_rd_resp_val & bus.tx_head_ptr_rd_resp_rdy;
  assign tl_got = bus.tx_tail_ptr_rd_resp_val & bus.tx_tail_ptr_rd_resp_rdy;
  assign reads_done = (st_done | st_fire) & (hd_done | hd_fire) & (tl_done | tl_fire);
  assign resps_done = (st_cap | st_got) & (hd_cap | hd_got) & (tl_cap | tl_got);
  // modular pointer distances; a window at or below inflight leaves nothing usable
  always_comb begin
    wnd_p = PTR_W'(wnd_q);
    mss_p = PTR_W'(MSS);
    avail = tail_q - snd_q;
    inflight = snd_q - head_q;
    usable = inflight >= wnd_p ? '0 : wnd_p - inflight;
    min_au = avail < usable ? avail : usable;
    len_c = min_au < mss_p ? min_au : mss_p;
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:            state_nxt = bus.sched_tx_req_val ? READ_STATE : IDLE;
      READ_STATE:      state_nxt = reads_done ? WAIT_STATE_RESP : READ_STATE;
      WAIT_STATE_RESP: state_nxt = resps_done ? CALCULATE : WAIT_STATE_RESP;
      CALCULATE:       state_nxt = len_c == '0 ? SCHEDULE : WRITEBACK;
      WRITEBACK:       state_nxt = bus.next_tx_state_wr_req_rdy ? PKT_OUT : WRITEBACK;
      PKT_OUT:         state_nxt = bus.tx_hdr_rdy ? SCHEDULE : PKT_OUT;
      SCHEDULE:        state_nxt = bus.tx_sched_update_rdy ? IDLE : SCHEDULE;
      default:         state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {st_done, hd_done, tl_done, st_cap, hd_cap, tl_cap, more_q} <= '0;
      flowid <= '0;
      snd_q <= '0;
      wnd_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.sched_tx_req_val) begin
        flowid <= bus.sched_tx_req_flowid;
        {st_done, hd_done, tl_done, st_cap, hd_cap, tl_cap} <= '0;
      end
      if (st_fire) st_done <= 1'b1;
      if (hd_fire) hd_done <= 1'b1;
      if (tl_fire) tl_done <= 1'b1;
      if (st_got) begin
        st_cap <= 1'b1;
        snd_q <= bus.curr_tx_state_rd_resp_snd_nxt;
        wnd_q <= bus.curr_tx_state_rd_resp_wnd;
      end
      if (hd_got) begin
        hd_cap <= 1'b1;
        head_q <= bus.tx_head_ptr_rd_resp_data;
      end
      if (tl_got) begin
        tl_cap <= 1'b1;
        tail_q <= bus.tx_tail_ptr_rd_resp_data;
      end
      if (state == CALCULATE) begin
        len_q <= len_c;
        more_q <= (avail > len_c) & (usable > len_c);
      end
    end
  end
endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// tb_tcp_tx_ctrl: directed checks of segment sizing, handshakes, backpressure and reset abort
module tb_tcp_tx_ctrl;
  logic clk = 0;
  logic rst_n = 0;
  int tests = 0;
  int failed = 0;
  int n_st = 0, n_hd = 0, n_tl = 0, n_wr = 0, n_hdr = 0, n_upd = 0;
  int b_st, b_hd, b_tl, b_wr, b_hdr, b_upd;
  tcp_tx_ctrl_if bus ();
  tcp_tx_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.curr_tx_state_rd_req_val & bus.curr_tx_state_rd_req_rdy) n_st <= n_st + 1;
    if (bus.tx_head_ptr_rd_req_val & bus.tx_head_ptr_rd_req_rdy) n_hd <= n_hd + 1;
    if (bus.tx_tail_ptr_rd_req_val & bus.tx_tail_ptr_rd_req_rdy) n_tl <= n_tl + 1;
    if (bus.next_tx_state_wr_req_val & bus.next_tx_state_wr_req_rdy) n_wr <= n_wr + 1;
    if (bus.tx_hdr_val & bus.tx_hdr_rdy) n_hdr <= n_hdr + 1;
    if (bus.tx_sched_update_val & bus.tx_sched_update_rdy) n_upd <= n_upd + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  task automatic snap();
    b_st = n_st; b_hd = n_hd; b_tl = n_tl; b_wr = n_wr; b_hdr = n_hdr; b_upd = n_upd;
  endtask
  task automatic all_rdy();
    bus.curr_tx_state_rd_req_rdy = 1;
    bus.tx_head_ptr_rd_req_rdy = 1;
    bus.tx_tail_ptr_rd_req_rdy = 1;
    bus.next_tx_state_wr_req_rdy = 1;
    bus.tx_hdr_rdy = 1;
    bus.tx_sched_update_rdy = 1;
  endtask
  task automatic set_resp(input logic [15:0] snd, input logic [15:0] wnd, input logic [15:0] head, input logic [15:0] tail, input logic v);
    bus.curr_tx_state_rd_resp_snd_nxt = snd;
    bus.curr_tx_state_rd_resp_wnd = wnd;
    bus.tx_head_ptr_rd_resp_data = head;
    bus.tx_tail_ptr_rd_resp_data = tail;
    bus.curr_tx_state_rd_resp_val = v;
    bus.tx_head_ptr_rd_resp_val = v;
    bus.tx_tail_ptr_rd_resp_val = v;
  endtask
  function automatic logic [2:0] req_vals();
    return {bus.curr_tx_state_rd_req_val, bus.tx_head_ptr_rd_req_val, bus.tx_tail_ptr_rd_req_val};
  endfunction
  function automatic logic [2:0] resp_rdys();
    return {bus.curr_tx_state_rd_resp_rdy, bus.tx_head_ptr_rd_resp_rdy, bus.tx_tail_ptr_rd_resp_rdy};
  endfunction
  function automatic logic [2:0] out_vals();
    return {bus.next_tx_state_wr_req_val, bus.tx_hdr_val, bus.tx_sched_update_val};
  endfunction
  task automatic cmd(input logic [7:0] fid);
    @(negedge clk);
    chk("idle_rdy", bus.tx_sched_req_rdy, 1);
    bus.sched_tx_req_val = 1;
    bus.sched_tx_req_flowid = fid;
    @(negedge clk);
    bus.sched_tx_req_val = 0;
  endtask
  // fixed-latency flow with every handshake immediate
  task automatic run_flow(input string tag, input logic [7:0] fid, input logic [15:0] snd, input logic [15:0] wnd,
                          input logic [15:0] head, input logic [15:0] tail, input logic [15:0] wlen,
                          input logic [15:0] wwb, input logic wmore);
    all_rdy();
    set_resp(snd, wnd, head, tail, 1);
    snap();
    cmd(fid);
    chk({tag, "_reqs"}, req_vals(), 3'b111);
    chk({tag, "_fid"}, bus.tx_pipe_flowid, fid);
    @(negedge clk);
    chk({tag, "_resp_rdy"}, resp_rdys(), 3'b111);
    @(negedge clk);
    chk({tag, "_calc_quiet"}, out_vals(), 3'b000);
    if (wlen != 0) begin
      @(negedge clk);
      chk({tag, "_wb_val"}, out_vals(), 3'b100);
      chk({tag, "_wb_ptr"}, bus.next_tx_state_wr_snd_nxt, wwb);
      @(negedge clk);
      chk({tag, "_hdr_val"}, out_vals(), 3'b010);
      chk({tag, "_hdr_seq"}, bus.tx_hdr_seq, snd);
      chk({tag, "_hdr_len"}, bus.tx_hdr_len, wlen);
    end
    @(negedge clk);
    chk({tag, "_upd_val"}, out_vals(), 3'b001);
    chk({tag, "_more"}, bus.tx_sched_update_more, wmore);
    @(negedge clk);
    chk({tag, "_back_idle"}, bus.tx_sched_req_rdy, 1);
    chk({tag, "_n_wr"}, n_wr - b_wr, wlen != 0 ? 1 : 0);
    chk({tag, "_n_hdr"}, n_hdr - b_hdr, wlen != 0 ? 1 : 0);
    chk({tag, "_n_upd"}, n_upd - b_upd, 1);
    set_resp(0, 0, 0, 0, 0);
  endtask
  initial begin
    bus.sched_tx_req_val = 0;
    bus.sched_tx_req_flowid = 0;
    all_rdy();
    set_resp(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_req_rdy", bus.tx_sched_req_rdy, 1);
    chk("rst_reqs", req_vals(), 0);
    chk("rst_resp_rdy", resp_rdys(), 0);
    chk("rst_outs", out_vals(), 0);
    chk("rst_fid", bus.tx_pipe_flowid, 0);
    chk("rst_data", {bus.tx_hdr_seq, bus.tx_hdr_len}, 0);
    rst_n = 1;
    run_flow("normal", 8'h11, 100, 65535, 100, 3100, 1460, 1560, 1);
    run_flow("nodata", 8'h12, 500, 65535, 500, 500, 0, 0, 0);
    run_flow("wrap", 8'h13, 16'hFF00, 4096, 16'hFF00, 16'h0100, 512, 16'h0100, 0);
    run_flow("win", 8'h14, 1000, 1200, 0, 5000, 200, 1200, 0);
    run_flow("win0", 8'h15, 1000, 800, 0, 5000, 0, 0, 0);
    // staggered: tail request stalls, responses return head, tail, state two cycles apart
    all_rdy();
    bus.tx_tail_ptr_rd_req_rdy = 0;
    set_resp(100, 65535, 100, 3100, 0);
    snap();
    cmd(8'h22);
    chk("stg_reqs", req_vals(), 3'b111);
    repeat (3) begin
      @(negedge clk);
      chk("stg_tail_hold", req_vals(), 3'b001);
    end
    bus.tx_tail_ptr_rd_req_rdy = 1;
    @(negedge clk);
    chk("stg_reqs_off", req_vals(), 3'b000);
    chk("stg_rdy_all", resp_rdys(), 3'b111);
    bus.tx_head_ptr_rd_resp_val = 1;
    @(negedge clk);
    bus.tx_head_ptr_rd_resp_val = 0;
    chk("stg_rdy_hd", resp_rdys(), 3'b101);
    @(negedge clk);
    bus.tx_tail_ptr_rd_resp_val = 1;
    @(negedge clk);
    bus.tx_tail_ptr_rd_resp_val = 0;
    chk("stg_rdy_tl", resp_rdys(), 3'b100);
    @(negedge clk);
    bus.curr_tx_state_rd_resp_val = 1;
    @(negedge clk);
    bus.curr_tx_state_rd_resp_val = 0;
    chk("stg_rdy_none", resp_rdys(), 3'b000);
    @(negedge clk);
    chk("stg_wb", {bus.next_tx_state_wr_req_val, bus.next_tx_state_wr_snd_nxt}, {1'b1, 16'd1560});
    @(negedge clk);
    chk("stg_hdr", {bus.tx_hdr_val, bus.tx_hdr_seq, bus.tx_hdr_len}, {1'b1, 16'd100, 16'd1460});
    @(negedge clk);
    chk("stg_upd", {bus.tx_sched_update_val, bus.tx_sched_update_more}, 2'b11);
    @(negedge clk);
    chk("stg_fires", {n_st - b_st, n_hd - b_hd, n_tl - b_tl}, {32'd1, 32'd1, 32'd1});
    // header backpressure
    all_rdy();
    bus.tx_hdr_rdy = 0;
    set_resp(100, 65535, 100, 3100, 1);
    snap();
    cmd(8'h33);
    repeat (3) @(negedge clk);
    chk("bp_wb", bus.next_tx_state_wr_snd_nxt, 1560);
    repeat (4) begin
      @(negedge clk);
      chk("bp_hdr_hold", {bus.tx_hdr_val, bus.tx_hdr_seq, bus.tx_hdr_len}, {1'b1, 16'd100, 16'd1460});
    end
    bus.tx_hdr_rdy = 1;
    @(negedge clk);
    chk("bp_upd", out_vals(), 3'b001);
    chk("bp_n_hdr", n_hdr - b_hdr, 1);
    @(negedge clk);
    // reset while writeback is pending
    all_rdy();
    bus.next_tx_state_wr_req_rdy = 0;
    set_resp(100, 65535, 100, 3100, 1);
    snap();
    cmd(8'h44);
    repeat (3) @(negedge clk);
    chk("rst_mid_wb", bus.next_tx_state_wr_req_val, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_outs", {req_vals(), resp_rdys(), out_vals()}, 0);
    chk("rst_mid_idle", bus.tx_sched_req_rdy, 1);
    @(negedge clk);
    rst_n = 1;
    all_rdy();
    repeat (3) @(negedge clk);
    chk("rst_mid_no_wr", n_wr - b_wr, 0);
    chk("rst_mid_no_upd", n_upd - b_upd, 0);
    chk("rst_mid_no_hdr", n_hdr - b_hdr, 0);
    run_flow("post_rst", 8'h55, 100, 65535, 100, 3100, 1460, 1560, 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
